// File: rtl/move_sequencer.sv
// move_sequencer: button-to-move controller with engine handshake, tile spawn search and game-over detection
module move_sequencer #(
    parameter int CELL_W      = 12,
    parameter int SPAWN_VALUE = 2,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_U,
    input  logic              btn_D,
    input  logic              btn_L,
    input  logic              btn_R,
    input  logic [3:0]        rand_idx,
    input  logic [15:0]       occ,
    input  logic              can_merge,
    output logic              eng_start,
    output logic [1:0]        eng_dir,
    input  logic              eng_done,
    input  logic              eng_changed,
    output logic              spawn_we,
    output logic [3:0]        spawn_idx,
    output logic [CELL_W-1:0] spawn_val,
    output logic              busy,
    output logic              game_over,
    output logic [CNT_W-1:0]  move_count
);
    typedef enum logic [3:0] {INIT, IDLE, START, WAIT_ENG, SCAN, SPAWN, SETTLE, CHECK, RELEASE, OVER} state_t;
    state_t state;
    logic [3:0] btn, prev, press, ptr, cnt;
    assign btn       = {btn_U, btn_D, btn_L, btn_R};
    assign press     = btn & ~prev;
    assign spawn_val = CELL_W'(SPAWN_VALUE);
    assign busy      = state != IDLE && state != OVER;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= INIT;
            eng_start  <= 1'b0;
            eng_dir    <= 2'b00;
            spawn_we   <= 1'b0;
            spawn_idx  <= 4'd0;
            game_over  <= 1'b0;
            move_count <= '0;
            prev       <= 4'd0;
            ptr        <= 4'd0;
            cnt        <= 4'd0;
        end else begin
            prev      <= btn;
            eng_start <= 1'b0;
            spawn_we  <= 1'b0;
            case (state)
                INIT: begin
                    ptr   <= rand_idx;
                    cnt   <= 4'd0;
                    state <= SCAN;
                end
                IDLE: if (|press) begin
                    eng_dir   <= press[3] ? 2'b00 : press[2] ? 2'b01 : press[1] ? 2'b10 : 2'b11;
                    eng_start <= 1'b1;
                    state     <= START;
                end
                START: state <= WAIT_ENG;
                WAIT_ENG: if (eng_done) begin
                    if (eng_changed) begin
                        move_count <= &move_count ? move_count : move_count + CNT_W'(1);
                        ptr        <= rand_idx;
                        cnt        <= 4'd0;
                        state      <= SCAN;
                    end else
                        state <= CHECK;
                end
                // cnt==15 on an occupied cell means all 16 cells have been tested
                SCAN: if (!occ[ptr]) begin
                    spawn_idx <= ptr;
                    spawn_we  <= 1'b1;
                    state     <= SPAWN;
                end else if (cnt == 4'd15)
                    state <= CHECK;
                else begin
                    ptr <= ptr + 4'd1;
                    cnt <= cnt + 4'd1;
                end
                SPAWN:  state <= SETTLE;
                SETTLE: state <= CHECK;
                CHECK: if (&occ && !can_merge) begin
                    game_over <= 1'b1;
                    state     <= OVER;
                end else
                    state <= RELEASE;
                RELEASE: if (btn == 4'd0) state <= IDLE;
                OVER:    state <= OVER;
                default: state <= INIT;
            endcase
        end
    end
endmodule

// File: doc/move_sequencer.md
Name: move_sequencer

Overview:
Top-level game controller for the 4x4 board datapath. It turns debounced direction buttons into single move commands and hands each one to the shift/merge engine over a start/done handshake. After every move that changes the board, it searches for an empty cell starting at a random index and issues a tile-spawn write. It also places the first tile after reset, counts moves, and flags game over.

Parameters:
CELL_W, 12, width of the spawn_val output (one board cell value)
SPAWN_VALUE, 2, value written into a newly spawned tile
CNT_W, 16, width of move_count

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
btn_U  in  1  debounced up button level, synchronous to clk
btn_D  in  1  debounced down button level
btn_L  in  1  debounced left button level
btn_R  in  1  debounced right button level
rand_idx  in  4  free-running random cell index
occ  in  16  bit k = 1 when board cell k is non-zero (k = row*4 + col)
can_merge  in  1  at least one pair of adjacent equal non-zero cells exists
eng_start  out  1  one-cycle pulse that starts a move in the engine
eng_dir  out  2  move direction: 00 U, 01 D, 10 L, 11 R
eng_done  in  1  one-cycle pulse: engine has finished the move
eng_changed  in  1  sampled with eng_done: board differs from its pre-move state
spawn_we  out  1  one-cycle write strobe for the new tile
spawn_idx  out  4  cell index of the spawn write
spawn_val  out  CELL_W  spawn data, always SPAWN_VALUE
busy  out  1  high in every state except IDLE and OVER
game_over  out  1  sticky game-over flag
move_count  out  CNT_W  number of moves that changed the board, saturating

Behaviour:
- Reset applies on any clk edge with rst_n=0, including mid-operation. Reset values: state INIT, eng_start=0, eng_dir=00, spawn_we=0, spawn_idx=0, game_over=0, move_count=0, button history=0. Reset aborts any pending engine handshake; a late eng_done is ignored because the state is no longer WAIT_ENG.
- Edge detect: prev_x is registered every cycle in every state. A press is btn_x & ~prev_x.
- Press priority: simultaneous presses resolve U > D > L > R. Only the winner is taken.
- Presses are acted on only in IDLE and are discarded in all other states. A button held through a move never retriggers.
- States:
  - INIT: load ptr=rand_idx and cnt=0, then go to SCAN. Places the first tile after reset.
  - IDLE: on a press, latch eng_dir and go to START.
  - START: eng_start=1 for exactly one cycle (the cycle after the press was seen), then go to WAIT_ENG.
  - WAIT_ENG: eng_dir is held stable.
    - eng_done with eng_changed=1: move_count+1 (saturating at all ones), load ptr=rand_idx and cnt=0, go to SCAN.
    - eng_done with eng_changed=0: go to CHECK.
    - No timeout.
  - SCAN: test one cell per cycle.
    - occ[ptr]=0: spawn_idx=ptr, go to SPAWN.
    - Otherwise: ptr=(ptr+1) mod 16 (15 wraps to 0), cnt+1.
    - After 16 occupied cells: go to CHECK without spawning.
    - Worst-case SCAN is 16 cycles.
  - SPAWN: spawn_we=1 for one cycle with spawn_idx and spawn_val valid, then go to SETTLE.
  - SETTLE: wait one cycle so occ and can_merge reflect the new tile, then go to CHECK.
  - CHECK: occ=16'hFFFF and can_merge=0 goes to OVER; otherwise go to RELEASE.
  - RELEASE: wait until all four buttons are low, then go to IDLE.
  - OVER: game_over=1. Stays here until reset; buttons are ignored.
- eng_start and spawn_we are never asserted in the same cycle.
- eng_done seen outside WAIT_ENG is ignored.

Test Plan:
- Reset with occ=0, rand_idx=5 -> after release, first clk gives INIT. The next cycle is SCAN; spawn_we pulses with spawn_idx=5, spawn_val=2. move_count=0. busy drops after RELEASE.
- btn_L rising in IDLE -> eng_start one cycle later with eng_dir=10. Then eng_done with eng_changed=1, rand_idx=14, occ=16'h4000|16'h8000|16'h0000 (cells 14 and 15 set) -> SCAN wraps 14, 15, 0; spawn_idx=0; move_count=1.
- btn_U and btn_R rise in the same cycle -> eng_dir=00. A btn_D press during WAIT_ENG is ignored. btn_U held after done -> no second eng_start until all buttons low and a new edge.
- eng_done with eng_changed=0, occ=16'h00FF -> no spawn_we, move_count unchanged, returns to IDLE after release.
- Move changes board, spawn fills the last empty cell: SETTLE sees occ=16'hFFFF, can_merge=0 -> game_over=1, busy=0. Further presses produce no eng_start.
- Assert rst_n=0 during WAIT_ENG, then deliver eng_done -> done is ignored, game_over=0, move_count=0, INIT spawn repeats.
